// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, stall, branch/jump redirect,
// exception entry and eret return, with one buffered redirect across stalls.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] IMEM_LO      = 32'h0000_3000,
  parameter logic [WIDTH-1:0] IMEM_HI      = 32'h0000_6FFC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             exc_adel,
  output logic             pend_valid
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pend_target;

  // Wraps naturally at 2^WIDTH; the wrap itself raises no error.
  assign pc_seq     = pc + STEP_W;
  assign pend_valid = (state == PEND);

  // Informational only: CP0 decides whether to raise exc_req.
  assign exc_adel = (|(pc & ALIGN_MASK)) | (pc < IMEM_LO) | (pc > IMEM_HI);

  // NOTE: state registers use non-blocking assignments so every branch of the
  // priority chain reads the pre-edge values of pc and state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_ADDR;
      state       <= RUN;
      pend_target <= '0;
    end else if (exc_req) begin
      pc    <= HANDLER_ADDR;
      state <= RUN;
    end else if (eret) begin
      pc    <= epc;
      state <= RUN;
    end else if (stall) begin
      // Latest redirect seen during a stall replaces any earlier buffered one.
      if (redirect) begin
        pend_target <= redirect_target;
        state       <= PEND;
      end
    end else if (redirect) begin
      pc    <= redirect_target;
      state <= RUN;
    end else if (state == PEND) begin
      pc    <= pend_target;
      state <= RUN;
    end else begin
      pc <= pc_seq;
    end
  end

endmodule
